// File: rtl/g25_sha256_led_out_pio.sv
// g25_sha256_led_out_pio
// Avalon-MM output PIO driving the board LEDs of the SHA256 system.
// Registers: DATA, BLINK_MASK, BLINK_PER, STATUS, OUTSET and OUTCLEAR.
// Reads have a one-cycle latency and there are no wait states.
// Optional blink engine: define G25_LED_PIO_BLINK_EN to build it.
// Without that macro there are no blink registers, phase is fixed at 1 and
// out_port follows the data register directly.
module g25_sha256_led_out_pio #(
   parameter int unsigned      WIDTH       = 10,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [31:0]      PERIOD_RST  = 32'd25000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   // Zero-extend a WIDTH-bit value to the 32-bit bus (safe for WIDTH == 32).
   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r          = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   logic             wr_en;
   logic [WIDTH-1:0] wdata_w;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata_w      = writedata[WIDTH-1:0];
   // Upper write-data bits are intentionally dropped.
   assign unused_wdata = ^writedata;

   // Signals shared by both build variants.
   logic             phase_w;
   logic [WIDTH-1:0] gate_w;
   logic [WIDTH-1:0] mask_rd;
   logic [31:0]      period_rd;

   // ---------------------------------------------------------------------
   // Data register with atomic set/clear
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] data_q, data_d;

   // Next data value: plain write, OR-in (OUTSET) or AND-out (OUTCLEAR).
   always_comb begin
      data_d = data_q;
      if (wr_en) begin
         case (address)
            3'd0:    data_d = wdata_w;
            3'd4:    data_d = data_q | wdata_w;
            3'd5:    data_d = data_q & ~wdata_w;
            default: data_d = data_q;
         endcase
      end
   end

   // Data register state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) data_q <= RESET_VALUE;
      else          data_q <= data_d;
   end

`ifdef G25_LED_PIO_BLINK_EN
   // ---------------------------------------------------------------------
   // Blink engine: phase 1 = LEDs on, phase 0 = masked bits forced off
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [31:0]      period_q, period_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             phase_q, phase_d;

   // Mask/period writes and half-period counter. A period write restarts
   // the count so a smaller period can never leave cnt stranded above it.
   always_comb begin
      mask_d   = mask_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      if (wr_en && address == 3'd1) begin
         mask_d = wdata_w;
      end
      if (wr_en && address == 3'd2) begin
         period_d = writedata;
         cnt_d    = '0;
         phase_d  = 1'b1;
      end else if (period_q == 32'd0) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == period_q - 32'd1) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Blink engine state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q   <= '0;
         period_q <= PERIOD_RST;
         cnt_q    <= '0;
         phase_q  <= 1'b1;
      end else begin
         mask_q   <= mask_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
      end
   end

   assign phase_w   = phase_q;
   assign gate_w    = mask_q & {WIDTH{~phase_q}};
   assign mask_rd   = mask_q;
   assign period_rd = period_q;
`else
   logic [31:0] unused_period;

   assign unused_period = PERIOD_RST;
   assign phase_w       = 1'b1;
   assign gate_w        = '0;
   assign mask_rd       = '0;
   assign period_rd     = '0;
`endif

   // ---------------------------------------------------------------------
   // LED drive: purely from registers, so no bus-to-pin combinational path
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_out
         assign out_port[gi] = data_q[gi] & ~gate_w[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Registered read path (address decoded every cycle, chipselect ignored)
   // ---------------------------------------------------------------------
   logic [31:0] readdata_q, readdata_d;

   // Read mux; DATA returns the stored value, not the blinked one.
   always_comb begin
      readdata_d = '0;
      case (address)
         3'd0: readdata_d = zext(data_q);
         3'd1: readdata_d = zext(mask_rd);
         3'd2: readdata_d = period_rd;
         3'd3: begin
            readdata_d     = zext(out_port);
            readdata_d[31] = phase_w;
         end
         default: readdata_d = '0;
      endcase
   end

   // Read data register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata_q <= '0;
      else          readdata_q <= readdata_d;
   end

   assign readdata = readdata_q;

endmodule
